// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port controller: bus widths, default
// strobe timing, FSM state encoding and the request record.
package sram_pkg;

  localparam int ADDR_W        = 18;
  localparam int DATA_W        = 16;
  localparam int WR_CYCLES_DEF = 2;
  localparam int RD_CYCLES_DEF = 2;
  localparam int CNT_W         = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SETUP  = 3'd1,
    WR_STROBE = 3'd2,
    WR_HOLD   = 3'd3,
    RD_SETUP  = 3'd4,
    RD_WAIT   = 3'd5,
    RD_DONE   = 3'd6
  } state_t;

  // One queued or in-flight access. data is meaningful for writes only.
  typedef struct packed {
    logic              is_rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  // Down-counter load value for a phase lasting 'cycles' clocks; the phase
  // ends on the cycle the counter reads zero.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/pulse_edge.sv
// Rising-edge detector for a level request input. Holds the one-cycle
// delayed copy of the input; a level held high produces a single request.
module pulse_edge (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  output logic rise
);

  logic pulse_q;

  // Delay register; cleared on reset so an input already high at release
  // is seen as a fresh request on the first clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pulse_q <= 1'b0;
    else     pulse_q <= pulse;
  end

  assign rise = pulse & ~pulse_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// Asynchronous SRAM port sequencer. Turns write/read request pulses into
// chip-pin timing with programmable strobe lengths, and queues one request
// that arrives while an access is in flight.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | chip deselected, bus released, ready for a request
//   WR_SETUP  | address and data driven, CE_N low, WE_N still high
//   WR_STROBE | WE_N low for WR_CYCLES cycles
//   WR_HOLD   | WE_N high, address/data held one more cycle
//   RD_SETUP  | address driven, CE_N and OE_N low
//   RD_WAIT   | OE_N low for RD_CYCLES cycles, DQ sampled in the last
//   RD_DONE   | OE_N high, rdata updated, rdata_valid pulses
module sram_port_ctrl
  import sram_pkg::*;
#(
  parameter int WR_CYCLES = WR_CYCLES_DEF,
  parameter int RD_CYCLES = RD_CYCLES_DEF
) (
  input  logic              SRAM_CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              writePulse,
  input  logic              readPulse,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              dropped
);

  localparam logic [CNT_W-1:0] WR_LOAD = cnt_load(WR_CYCLES);
  localparam logic [CNT_W-1:0] RD_LOAD = cnt_load(RD_CYCLES);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              wr_edge, rd_edge;

  req_t              wr_req, rd_req;
  req_t              first_req, second_req;
  logic              first_v, second_v;

  req_t              pend;
  logic              pend_v;

  logic              start_v;
  req_t              start_req;
  logic              slot_load, slot_clear;
  req_t              slot_req;
  logic              drop;

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              dq_oe;
  logic              ce_n, oe_n, we_n, valid_c;
  logic              rd_sample;

  pulse_edge u_wr_edge (
    .clk   (SRAM_CLK),
    .rst   (reset),
    .pulse (writePulse),
    .rise  (wr_edge)
  );

  pulse_edge u_rd_edge (
    .clk   (SRAM_CLK),
    .rst   (reset),
    .pulse (readPulse),
    .rise  (rd_edge)
  );

  // Candidate requests this cycle; write always ranks ahead of read.
  always_comb begin
    wr_req     = '{is_rd: 1'b0, addr: addr_in, data: data_in};
    rd_req     = '{is_rd: 1'b1, addr: addr_in, data: '0};
    first_v    = wr_edge | rd_edge;
    first_req  = wr_edge ? wr_req : rd_req;
    second_v   = wr_edge & rd_edge;
    second_req = rd_req;
  end

  // Arbitration between the pending slot and new edges. A queued request
  // always starts ahead of a new one; whatever cannot start or be queued
  // is discarded and flagged.
  always_comb begin
    start_v    = 1'b0;
    start_req  = pend;
    slot_load  = 1'b0;
    slot_clear = 1'b0;
    slot_req   = pend;
    drop       = 1'b0;
    if (state == IDLE) begin
      if (pend_v) begin
        start_v    = 1'b1;
        start_req  = pend;
        slot_clear = 1'b1;
        if (first_v) begin
          slot_load = 1'b1;
          slot_req  = first_req;
        end
        if (second_v) drop = 1'b1;
      end else begin
        if (first_v) begin
          start_v   = 1'b1;
          start_req = first_req;
        end
        if (second_v) begin
          slot_load = 1'b1;
          slot_req  = second_req;
        end
      end
    end else begin
      if (pend_v) begin
        drop = first_v;
      end else begin
        if (first_v) begin
          slot_load = 1'b1;
          slot_req  = first_req;
        end
        if (second_v) drop = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge SRAM_CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and pin control decode.
  always_comb begin
    next_state = state;
    ce_n       = 1'b0;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    dq_oe      = 1'b0;
    valid_c    = 1'b0;
    case (state)
      IDLE: begin
        ce_n = 1'b1;
        if (start_v) next_state = start_req.is_rd ? RD_SETUP : WR_SETUP;
      end
      WR_SETUP: begin
        dq_oe      = 1'b1;
        next_state = WR_STROBE;
      end
      WR_STROBE: begin
        dq_oe = 1'b1;
        we_n  = 1'b0;
        if (cnt == '0) next_state = WR_HOLD;
      end
      WR_HOLD: begin
        dq_oe      = 1'b1;
        next_state = IDLE;
      end
      RD_SETUP: begin
        oe_n       = 1'b0;
        next_state = RD_WAIT;
      end
      RD_WAIT: begin
        oe_n = 1'b0;
        if (cnt == '0) next_state = RD_DONE;
      end
      RD_DONE: begin
        valid_c    = 1'b1;
        next_state = IDLE;
      end
      default: begin
        ce_n       = 1'b1;
        next_state = IDLE;
      end
    endcase
  end

  assign rd_sample = (state == RD_WAIT) && (cnt == '0);

  // Phase timer: loaded in the setup state, counts down through the strobe.
  always_ff @(posedge SRAM_CLK or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == WR_SETUP) begin
      cnt <= WR_LOAD;
    end else if (state == RD_SETUP) begin
      cnt <= RD_LOAD;
    end else if ((state == WR_STROBE || state == RD_WAIT) && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // One-deep pending slot.
  always_ff @(posedge SRAM_CLK or posedge reset) begin
    if (reset) begin
      pend_v <= 1'b0;
      pend   <= '0;
    end else if (slot_load) begin
      pend_v <= 1'b1;
      pend   <= slot_req;
    end else if (slot_clear) begin
      pend_v <= 1'b0;
    end
  end

  // Address/data of the access in flight; held until the next one starts.
  always_ff @(posedge SRAM_CLK or posedge reset) begin
    if (reset) begin
      cur_addr <= '0;
      cur_data <= '0;
    end else if (start_v) begin
      cur_addr <= start_req.addr;
      cur_data <= start_req.data;
    end
  end

  // Read data capture on the last wait cycle; holds until the next read.
  always_ff @(posedge SRAM_CLK or posedge reset) begin
    if (reset)          rdata <= '0;
    else if (rd_sample) rdata <= SRAM_DQ;
  end

  // Sticky lost-request flag.
  always_ff @(posedge SRAM_CLK or posedge reset) begin
    if (reset)     dropped <= 1'b0;
    else if (drop) dropped <= 1'b1;
  end

  assign SRAM_ADDR   = cur_addr;
  assign SRAM_DQ     = dq_oe ? cur_data : 'z;
  assign SRAM_CE_N   = ce_n;
  assign SRAM_OE_N   = oe_n;
  assign SRAM_WE_N   = we_n;
  assign SRAM_UB_N   = ce_n;
  assign SRAM_LB_N   = ce_n;
  assign rdata_valid = valid_c;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a small behavioural SRAM on the bus.
module tb_sram_port_ctrl;

  logic        SRAM_CLK = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] addr_in = '0;
  logic [15:0] data_in = '0;
  logic        writePulse = 1'b0;
  logic        readPulse = 1'b0;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  logic [15:0] rdata;
  logic        rdata_valid, busy, dropped;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  logic        probe_en = 1'b0;
  logic        model_en;
  int          we_low_cnt, busy_cnt, valid_cnt;
  logic [15:0] last_rdata;

  always #5 SRAM_CLK = ~SRAM_CLK;

  sram_port_ctrl #(.WR_CYCLES(2), .RD_CYCLES(2)) dut (
    .SRAM_CLK    (SRAM_CLK),
    .reset       (reset),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .writePulse  (writePulse),
    .readPulse   (readPulse),
    .SRAM_ADDR   (SRAM_ADDR),
    .SRAM_DQ     (SRAM_DQ),
    .SRAM_CE_N   (SRAM_CE_N),
    .SRAM_OE_N   (SRAM_OE_N),
    .SRAM_WE_N   (SRAM_WE_N),
    .SRAM_UB_N   (SRAM_UB_N),
    .SRAM_LB_N   (SRAM_LB_N),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .dropped     (dropped)
  );

  // SRAM model: drives on output enable, stores on write strobe. probe_en
  // puts a known pattern on the bus to show the controller has released it.
  assign model_en = !SRAM_CE_N && !SRAM_OE_N;
  assign SRAM_DQ  = probe_en ? 16'h5A5A : (model_en ? mem[SRAM_ADDR[7:0]] : 16'hzzzz);

  always @(negedge SRAM_CLK) begin
    if (!reset && !SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
  end

  // Pin invariants checked every cycle outside reset.
  always @(negedge SRAM_CLK) begin
    if (!reset) begin
      checks++;
      if (!SRAM_WE_N && !SRAM_OE_N) begin
        errors++;
        $display("FAIL we_oe_overlap got we_n=%b oe_n=%b want not both 0", SRAM_WE_N, SRAM_OE_N);
      end
      checks++;
      if (SRAM_UB_N !== SRAM_CE_N || SRAM_LB_N !== SRAM_CE_N) begin
        errors++;
        $display("FAIL byte_enables got ub_n=%b lb_n=%b want %b", SRAM_UB_N, SRAM_LB_N, SRAM_CE_N);
      end
    end
  end

  task automatic tick();
    @(posedge SRAM_CLK);
    #1;
  endtask

  task automatic tick_count();
    tick();
    if (!SRAM_WE_N) we_low_cnt++;
    if (busy) busy_cnt++;
    if (rdata_valid) begin
      valid_cnt++;
      last_rdata = rdata;
    end
  endtask

  task automatic clear_counts();
    we_low_cnt = 0;
    busy_cnt   = 0;
    valid_cnt  = 0;
    last_rdata = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_pins got %b want 11111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N});
    end
    checks++;
    if (SRAM_ADDR !== 18'h0 || rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_addr_rdata got addr=%h rdata=%h want 0 0", SRAM_ADDR, rdata);
    end
    checks++;
    if ({rdata_valid, busy, dropped} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000", {rdata_valid, busy, dropped});
    end
    probe_en = 1'b1;
    #1;
    checks++;
    if (SRAM_DQ !== 16'h5A5A) begin
      errors++;
      $display("FAIL reset_dq_hiz got %h want 5a5a", SRAM_DQ);
    end
    probe_en = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    logic [0:4] we_t, busy_t, ce_t;
    we_t   = 5'b10011;
    busy_t = 5'b11110;
    ce_t   = 5'b00001;
    addr_in    = 18'h00005;
    data_in    = 16'hAAAA;
    writePulse = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      writePulse = 1'b0;
      checks++;
      if (SRAM_WE_N !== we_t[i] || busy !== busy_t[i] || SRAM_CE_N !== ce_t[i]) begin
        errors++;
        $display("FAIL write_seq[%0d] got we_n=%b busy=%b ce_n=%b want %b %b %b",
                 i, SRAM_WE_N, busy, SRAM_CE_N, we_t[i], busy_t[i], ce_t[i]);
      end
      if (i < 4) begin
        checks++;
        if (SRAM_DQ !== 16'hAAAA || SRAM_ADDR !== 18'h00005 || SRAM_OE_N !== 1'b1) begin
          errors++;
          $display("FAIL write_bus[%0d] got dq=%h addr=%h oe_n=%b want aaaa 00005 1",
                   i, SRAM_DQ, SRAM_ADDR, SRAM_OE_N);
        end
      end
    end
    probe_en = 1'b1;
    #1;
    checks++;
    if (SRAM_DQ !== 16'h5A5A) begin
      errors++;
      $display("FAIL write_idle_hiz got %h want 5a5a", SRAM_DQ);
    end
    probe_en = 1'b0;
  endtask

  task automatic test_read();
    logic [0:4] oe_t, valid_t, busy_t, ce_t;
    oe_t    = 5'b00011;
    valid_t = 5'b00010;
    busy_t  = 5'b11110;
    ce_t    = 5'b00001;
    tick();
    addr_in   = 18'h00005;
    data_in   = 16'h0000;
    readPulse = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      readPulse = 1'b0;
      checks++;
      if (SRAM_OE_N !== oe_t[i] || rdata_valid !== valid_t[i] || busy !== busy_t[i] ||
          SRAM_CE_N !== ce_t[i] || SRAM_WE_N !== 1'b1) begin
        errors++;
        $display("FAIL read_seq[%0d] got oe_n=%b valid=%b busy=%b ce_n=%b we_n=%b want %b %b %b %b 1",
                 i, SRAM_OE_N, rdata_valid, busy, SRAM_CE_N, SRAM_WE_N,
                 oe_t[i], valid_t[i], busy_t[i], ce_t[i]);
      end
      if (i >= 3) begin
        checks++;
        if (rdata !== 16'hAAAA) begin
          errors++;
          $display("FAIL read_data[%0d] got %h want aaaa", i, rdata);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [0:9] we_t, oe_t, busy_t, valid_t;
    we_t    = 10'b1001111111;
    oe_t    = 10'b1111100011;
    busy_t  = 10'b1111011110;
    valid_t = 10'b0000000010;
    tick();
    addr_in    = 18'h00010;
    data_in    = 16'h1234;
    writePulse = 1'b1;
    readPulse  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      writePulse = 1'b0;
      readPulse  = 1'b0;
      checks++;
      if (SRAM_WE_N !== we_t[i] || SRAM_OE_N !== oe_t[i] || busy !== busy_t[i] ||
          rdata_valid !== valid_t[i]) begin
        errors++;
        $display("FAIL simul_seq[%0d] got we_n=%b oe_n=%b busy=%b valid=%b want %b %b %b %b",
                 i, SRAM_WE_N, SRAM_OE_N, busy, rdata_valid, we_t[i], oe_t[i], busy_t[i], valid_t[i]);
      end
    end
    checks++;
    if (rdata !== 16'h1234 || dropped !== 1'b0) begin
      errors++;
      $display("FAIL simul_result got rdata=%h dropped=%b want 1234 0", rdata, dropped);
    end
  endtask

  task automatic test_drop();
    tick();
    clear_counts();
    addr_in    = 18'h00020;
    data_in    = 16'h0F0F;
    writePulse = 1'b1;
    tick_count();
    writePulse = 1'b0;
    readPulse  = 1'b1;
    addr_in    = 18'h00020;
    tick_count();
    checks++;
    if (dropped !== 1'b0) begin
      errors++;
      $display("FAIL drop_first_queued got %b want 0", dropped);
    end
    readPulse  = 1'b0;
    writePulse = 1'b1;
    addr_in    = 18'h00022;
    data_in    = 16'hDEAD;
    tick_count();
    checks++;
    if (dropped !== 1'b1) begin
      errors++;
      $display("FAIL drop_second got %b want 1", dropped);
    end
    writePulse = 1'b0;
    readPulse  = 1'b1;
    addr_in    = 18'h00023;
    tick_count();
    readPulse = 1'b0;
    tick_count();
    tick_count();
    checks++;
    if (SRAM_OE_N !== 1'b0 || SRAM_ADDR !== 18'h00020) begin
      errors++;
      $display("FAIL drop_read_start got oe_n=%b addr=%h want 0 00020", SRAM_OE_N, SRAM_ADDR);
    end
    for (int i = 0; i < 12; i++) tick_count();
    checks++;
    if (we_low_cnt != 2 || busy_cnt != 8 || valid_cnt != 1) begin
      errors++;
      $display("FAIL drop_counts got we_low=%0d busy=%0d valid=%0d want 2 8 1", we_low_cnt, busy_cnt, valid_cnt);
    end
    checks++;
    if (last_rdata !== 16'h0F0F || mem[8'h22] !== 16'h0000 || dropped !== 1'b1) begin
      errors++;
      $display("FAIL drop_result got rdata=%h mem22=%h dropped=%b want 0f0f 0000 1",
               last_rdata, mem[8'h22], dropped);
    end
  endtask

  task automatic test_held_pulse();
    clear_counts();
    addr_in    = 18'h00030;
    data_in    = 16'h3333;
    writePulse = 1'b1;
    for (int i = 0; i < 10; i++) tick_count();
    writePulse = 1'b0;
    for (int i = 0; i < 8; i++) tick_count();
    checks++;
    if (we_low_cnt != 2 || busy_cnt != 4 || mem[8'h30] !== 16'h3333) begin
      errors++;
      $display("FAIL held_pulse got we_low=%0d busy=%0d mem30=%h want 2 4 3333", we_low_cnt, busy_cnt, mem[8'h30]);
    end
  endtask

  task automatic test_reset_mid_write();
    addr_in    = 18'h00040;
    data_in    = 16'h4444;
    writePulse = 1'b1;
    tick();
    writePulse = 1'b0;
    tick();
    checks++;
    if (SRAM_WE_N !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_strobe got we_n=%b want 0", SRAM_WE_N);
    end
    #2;
    reset    = 1'b1;
    probe_en = 1'b1;
    #1;
    checks++;
    if ({SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, busy, dropped} !== 5'b11100) begin
      errors++;
      $display("FAIL midrst_pins got we_n,ce_n,oe_n,busy,dropped=%b want 11100",
               {SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, busy, dropped});
    end
    checks++;
    if (SRAM_DQ !== 16'h5A5A || SRAM_ADDR !== 18'h0 || rdata !== 16'h0) begin
      errors++;
      $display("FAIL midrst_bus got dq=%h addr=%h rdata=%h want 5a5a 0 0", SRAM_DQ, SRAM_ADDR, rdata);
    end
    probe_en = 1'b0;
    tick();
    reset = 1'b0;
    clear_counts();
    for (int i = 0; i < 6; i++) tick_count();
    checks++;
    if (we_low_cnt != 0 || busy_cnt != 0 || valid_cnt != 0 || mem[8'h40] !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_after got we_low=%0d busy=%0d valid=%0d mem40=%h want 0 0 0 0000",
               we_low_cnt, busy_cnt, valid_cnt, mem[8'h40]);
    end
  endtask

  task automatic test_reset_held_input();
    reset     = 1'b1;
    addr_in   = 18'h00020;
    readPulse = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (SRAM_OE_N !== 1'b0 || busy !== 1'b1 || SRAM_ADDR !== 18'h00020) begin
      errors++;
      $display("FAIL held_at_release got oe_n=%b busy=%b addr=%h want 0 1 00020", SRAM_OE_N, busy, SRAM_ADDR);
    end
    readPulse = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 16'h0F0F) begin
      errors++;
      $display("FAIL held_at_release_data got valid=%b rdata=%h want 1 0f0f", rdata_valid, rdata);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_drop();
    test_held_pulse();
    test_reset_mid_write();
    test_reset_held_input();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
